// File: rtl/alu_op_decoder.sv
// Decodes a MIPS instruction word into ALUFun/Sign and operand selects, held in a
// 1-deep valid/ready register with flush; counts accepted illegal encodings.
module alu_op_decoder #(
  parameter int          CNT_W       = 8,
  parameter logic [5:0]  ILLEGAL_FUN = 6'b000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       alu_fun,
  output logic             alu_sign,
  output logic             a_shamt,
  output logic             b_imm,
  output logic             b_zero,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;
  localparam logic [5:0] FUN_AND = 6'b011000;
  localparam logic [5:0] FUN_OR  = 6'b011110;
  localparam logic [5:0] FUN_XOR = 6'b010110;
  localparam logic [5:0] FUN_NOR = 6'b010001;
  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;
  localparam logic [5:0] FUN_SRA = 6'b100011;
  localparam logic [5:0] FUN_EQ  = 6'b110011;
  localparam logic [5:0] FUN_NEQ = 6'b110001;
  localparam logic [5:0] FUN_LT  = 6'b110101;
  localparam logic [5:0] FUN_LEZ = 6'b111101;
  localparam logic [5:0] FUN_GEZ = 6'b111001;
  localparam logic [5:0] FUN_GTZ = 6'b111111;

  logic [5:0]       w_op;
  logic [4:0]       w_rt;
  logic [5:0]       w_funct;
  logic             w_unused;
  logic             w_accept;
  logic [5:0]       w_fun;
  logic             w_sign;
  logic             w_shamt;
  logic             w_imm;
  logic             w_zero;
  logic             w_ill;

  logic             r_valid;
  logic [5:0]       r_fun;
  logic             r_sign;
  logic             r_shamt;
  logic             r_imm;
  logic             r_zero;
  logic             r_ill;
  logic [CNT_W-1:0] r_cnt;

  assign w_op     = instr[31:26];
  assign w_rt     = instr[20:16];
  assign w_funct  = instr[5:0];
  assign w_unused = ^{instr[25:21], instr[15:6]};

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_comb begin
    w_fun   = ILLEGAL_FUN;
    w_sign  = 1'b1;
    w_shamt = 1'b0;
    w_imm   = 1'b0;
    w_zero  = 1'b0;
    w_ill   = 1'b0;
    case (w_op)
      6'h00: begin
        case (w_funct)
          6'h20: w_fun = FUN_ADD;
          6'h21: begin w_fun = FUN_ADD; w_sign = 1'b0; end
          6'h22: w_fun = FUN_SUB;
          6'h23: begin w_fun = FUN_SUB; w_sign = 1'b0; end
          6'h24: w_fun = FUN_AND;
          6'h25: w_fun = FUN_OR;
          6'h26: w_fun = FUN_XOR;
          6'h27: w_fun = FUN_NOR;
          6'h2a: w_fun = FUN_LT;
          6'h2b: begin w_fun = FUN_LT; w_sign = 1'b0; end
          6'h00: begin w_fun = FUN_SLL; w_shamt = 1'b1; end
          6'h02: begin w_fun = FUN_SRL; w_shamt = 1'b1; end
          6'h03: begin w_fun = FUN_SRA; w_shamt = 1'b1; end
          6'h08, 6'h09: w_fun = FUN_ADD;
          default: w_ill = 1'b1;
        endcase
      end
      6'h08: begin w_fun = FUN_ADD; w_imm = 1'b1; end
      6'h09: begin w_fun = FUN_ADD; w_imm = 1'b1; w_sign = 1'b0; end
      6'h0c: begin w_fun = FUN_AND; w_imm = 1'b1; end
      6'h0d: begin w_fun = FUN_OR;  w_imm = 1'b1; end
      6'h0e: begin w_fun = FUN_XOR; w_imm = 1'b1; end
      6'h0a: begin w_fun = FUN_LT;  w_imm = 1'b1; end
      6'h0b: begin w_fun = FUN_LT;  w_imm = 1'b1; w_sign = 1'b0; end
      6'h0f: begin w_fun = FUN_ADD; w_imm = 1'b1; w_sign = 1'b0; end
      6'h23, 6'h2b: begin w_fun = FUN_ADD; w_imm = 1'b1; end
      6'h04: w_fun = FUN_EQ;
      6'h05: w_fun = FUN_NEQ;
      6'h06: w_fun = FUN_LEZ;
      6'h07: w_fun = FUN_GTZ;
      6'h01: begin
        // REGIMM: rt selects bgez/bltz; bltz compares rs against a forced-zero B
        if (w_rt == 5'd1) begin
          w_fun = FUN_GEZ;
        end else if (w_rt == 5'd0) begin
          w_fun  = FUN_LT;
          w_zero = 1'b1;
        end else begin
          w_ill = 1'b1;
        end
      end
      6'h02, 6'h03: w_fun = FUN_ADD;
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_fun = ILLEGAL_FUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_fun   <= 6'b000000;
      r_sign  <= 1'b1;
      r_shamt <= 1'b0;
      r_imm   <= 1'b0;
      r_zero  <= 1'b0;
      r_ill   <= 1'b0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_fun   <= w_fun;
      r_sign  <= w_sign;
      r_shamt <= w_shamt;
      r_imm   <= w_imm;
      r_zero  <= w_zero;
      r_ill   <= w_ill;
      if (w_ill && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign alu_fun     = r_fun;
  assign alu_sign    = r_sign;
  assign a_shamt     = r_shamt;
  assign b_imm       = r_imm;
  assign b_zero      = r_zero;
  assign illegal     = r_ill;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: decode table, latency, backpressure, flush,
// illegal counter saturation and asynchronous reset.
module tb_alu_op_decoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic        a_shamt;
  logic        b_imm;
  logic        b_zero;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  int n_chk = 0;
  int n_err = 0;

  alu_op_decoder #(.CNT_W(8), .ILLEGAL_FUN(6'b000000)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_fun(alu_fun), .alu_sign(alu_sign), .a_shamt(a_shamt), .b_imm(b_imm),
    .b_zero(b_zero), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [5:0]  fun;
    logic        s;
    logic        sh;
    logic        im;
    logic        z;
    logic        il;
  } vec_t;

  function automatic logic [31:0] r_ins(input logic [5:0] f);
    return {6'h00, 20'h12345, f};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op);
    return {op, 26'h0abcdef};
  endfunction
  function automatic logic [31:0] ri_ins(input logic [4:0] rt);
    return {6'h01, 5'h03, rt, 16'hbeef};
  endfunction

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic check_out(input string tag, input vec_t v);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".fun"},   alu_fun,   v.fun);
    check({tag, ".sign"},  alu_sign,  v.s);
    check({tag, ".shamt"}, a_shamt,   v.sh);
    check({tag, ".imm"},   b_imm,     v.im);
    check({tag, ".zero"},  b_zero,    v.z);
    check({tag, ".ill"},   illegal,   v.il);
  endtask

  initial begin
    tbl[0]  = '{r_ins(6'h20),   6'b000000, 1, 0, 0, 0, 0}; // add
    tbl[1]  = '{r_ins(6'h22),   6'b000001, 1, 0, 0, 0, 0}; // sub
    tbl[2]  = '{r_ins(6'h2b),   6'b110101, 0, 0, 0, 0, 0}; // sltu
    tbl[3]  = '{r_ins(6'h03),   6'b100011, 1, 1, 0, 0, 0}; // sra
    tbl[4]  = '{i_ins(6'h04),   6'b110011, 1, 0, 0, 0, 0}; // beq
    tbl[5]  = '{ri_ins(5'd0),   6'b110101, 1, 0, 0, 1, 0}; // bltz
    tbl[6]  = '{r_ins(6'h27),   6'b010001, 1, 0, 0, 0, 0}; // nor
    tbl[7]  = '{r_ins(6'h00),   6'b100000, 1, 1, 0, 0, 0}; // sll
    tbl[8]  = '{i_ins(6'h0f),   6'b000000, 0, 0, 1, 0, 0}; // lui
    tbl[9]  = '{i_ins(6'h0a),   6'b110101, 1, 0, 1, 0, 0}; // slti
    tbl[10] = '{ri_ins(5'd1),   6'b111001, 1, 0, 0, 0, 0}; // bgez
    tbl[11] = '{i_ins(6'h03),   6'b000000, 1, 0, 0, 0, 0}; // jal
    tbl[12] = '{r_ins(6'h08),   6'b000000, 1, 0, 0, 0, 0}; // jr
    tbl[13] = '{i_ins(6'h06),   6'b111101, 1, 0, 0, 0, 0}; // blez
    tbl[14] = '{i_ins(6'h07),   6'b111111, 1, 0, 0, 0, 0}; // bgtz
    tbl[15] = '{r_ins(6'h01),   6'b000000, 1, 0, 0, 0, 1}; // bad funct
    tbl[16] = '{ri_ins(5'd2),   6'b000000, 1, 0, 0, 0, 1}; // bad rt
    tbl[17] = '{r_ins(6'h21),   6'b000000, 0, 0, 0, 0, 0}; // addu
    tbl[18] = '{i_ins(6'h23),   6'b000000, 1, 0, 1, 0, 0}; // lw
    tbl[19] = '{r_ins(6'h02),   6'b100001, 1, 1, 0, 0, 0}; // srl
    tbl[20] = '{i_ins(6'h0b),   6'b110101, 0, 0, 1, 0, 0}; // sltiu
    tbl[21] = '{i_ins(6'h05),   6'b110001, 1, 0, 0, 0, 0}; // bne

    reset = 1'b0; in_valid = 1'b1; instr = tbl[0].ins; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", out_valid, 0);
    check("rst.ready", in_ready, 1);
    check("rst.cnt", illegal_cnt, 0);
    check("rst.fun", alu_fun, 0);
    check("rst.sign", alu_sign, 1);
    reset = 1'b1;

    // one op per cycle, each visible exactly one edge after it was presented
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i), tbl[i]);
      if (i + 1 < NV) instr = tbl[i + 1].ins;
      else in_valid = 1'b0;
    end
    @(posedge clk); #1;
    check("stream.drain", out_valid, 0);
    check("stream.cnt", illegal_cnt, 2);

    // backpressure
    in_valid = 1'b1; instr = i_ins(6'h08);
    @(posedge clk); #1;
    check_out("addi", '{32'h0, 6'b000000, 1, 0, 1, 0, 0});
    out_ready = 1'b0; instr = i_ins(6'h0d);
    #1;
    check("bp.ready0", in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_out($sformatf("bp.hold%0d", k), '{32'h0, 6'b000000, 1, 0, 1, 0, 0});
      check("bp.ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release", in_ready, 1);
    @(posedge clk); #1;
    check_out("ori", '{32'h0, 6'b011110, 1, 0, 1, 0, 0});
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp.nodup", out_valid, 0);

    // flush against a held op, with an illegal op presented that must not count
    in_valid = 1'b1; instr = i_ins(6'h0e);
    @(posedge clk); #1;
    check_out("xori", '{32'h0, 6'b010110, 1, 0, 1, 0, 0});
    instr = i_ins(6'h3f); flush = 1'b1;
    @(posedge clk); #1;
    check("flush.valid", out_valid, 0);
    check("flush.fun", alu_fun, 6'b010110);
    check("flush.cnt", illegal_cnt, 2);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("flush.noacc", out_valid, 0);

    // illegal flood saturates the counter
    in_valid = 1'b1; instr = i_ins(6'h3f);
    for (int k = 1; k <= 258; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("ill.cnt1", illegal_cnt, 3);
      if (k == 253) check("ill.cnt255", illegal_cnt, 255);
    end
    check("ill.sat", illegal_cnt, 255);
    check_out("ill", '{32'h0, 6'b000000, 1, 0, 0, 0, 1});
    in_valid = 1'b0;
    @(posedge clk); #1;

    // async reset while stalled
    in_valid = 1'b1; instr = i_ins(6'h08);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall.valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst.valid", out_valid, 0);
    check("arst.imm", b_imm, 0);
    check("arst.cnt", illegal_cnt, 0);
    check("arst.ready", in_ready, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post.valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
